down_counter_8b: RTL

- Loadable down counter / countdown timer. The companion to the team's 8-bit up counter.
- Counts a loaded value down to zero under the same SS (start/stop) enable.
- Flags terminal count and optionally auto-reloads for periodic ticks.
- Used as a timeout / period generator next to the up counter in the chapter-5 counter set.

---
 rtl/down_counter_8b_if.sv | 24 ++
 rtl/down_counter_8b.sv | 76 +++++++
 2 files changed

// File: rtl/down_counter_8b_if.sv
// down_counter_8b_if: control/status bundle for the loadable down counter.
//   SS        count enable (1 = run, 0 = hold)
//   load      synchronous load strobe
//   din       load value
//   reload_en auto-reload at terminal count
//   OUT       current count
//   tc        one-clock terminal-count pulse
//   busy      counter is running
//   done      counter has expired and waits for a load
interface down_counter_8b_if #(
    parameter int WIDTH = 8
);
    logic             SS;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             reload_en;
    logic [WIDTH-1:0] OUT;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (output SS, load, din, reload_en, input OUT, tc, busy, done);
    modport slave  (input SS, load, din, reload_en, output OUT, tc, busy, done);
endinterface

// File: rtl/down_counter_8b.sv
// down_counter_8b: loadable down counter / countdown timer with terminal-count pulse
// and optional auto-reload for periodic ticks.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  down_counter_8b_if.slave (SS, load, din, reload_en in; OUT, tc, busy, done out)
// Optional feature: define DOWN_CNT_PRESCALE_EN to take one decrement every PRESCALE
// enabled RUN cycles instead of every enabled RUN cycle.
module down_counter_8b #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input logic              clk,
    input logic              rst,
    down_counter_8b_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n, rld, rld_n;
    logic             tc, tc_n, tick;

    if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
        $error("PRESCALE must be in 1..256");
    end

`ifdef DOWN_CNT_PRESCALE_EN
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] pre;
    assign tick = pre == PW'(PRESCALE - 1);
    // Only enabled RUN cycles advance the window; SS=0 freezes it.
    always_ff @(posedge clk or posedge rst)
        if (rst) pre <= '0;
        else if (bus.load) pre <= '0;
        else if (state == RUN && bus.SS) pre <= tick ? '0 : pre + PW'(1);
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rld_n   = rld;
        tc_n    = 1'b0;
        if (bus.load) begin
            cnt_n   = bus.din;
            rld_n   = bus.din;
            state_n = bus.din != '0 ? RUN : DONE;
        end else if (state == RUN && bus.SS && tick) begin
            // OUT==0 is only reachable in RUN while auto-reloading, so it reloads.
            cnt_n   = cnt > ONE ? cnt - ONE : cnt == ONE ? '0 : rld;
            tc_n    = cnt == ONE;
            state_n = (cnt == ONE && !(bus.reload_en && rld != '0)) ? DONE : RUN;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rld   <= '0;
            tc    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rld   <= rld_n;
            tc    <= tc_n;
        end

    assign bus.OUT  = cnt;
    assign bus.tc   = tc;
    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;
endmodule
